generic_lscan_responder: RTL and testbench
==========================================

Name: generic_lscan_responder

Overview:
- Slave-side responder for the generic lscan bus.
- Accepts a command cycle from a master: CS, CMD, ADDR, BURST, SIZE, PRIORITY.
- Services each burst beat from an internal word memory: writes capture wDATA, reads drive rDATA.
- Paces every beat with STATUS and inserts programmable wait states.
- Used as a memory-model endpoint behind the lscan monitor in platform testbenches.

Parameters:
- WIDTH, 32, data and address width in bits; must be 32 or 64.
- DEPTH, 256, memory depth in words; power of two.
- WAIT_STATES, 0, number of STATUS-low cycles before every beat; range 0..15.

Ports:
- CLK  input  1  clock; all logic updates on the rising edge.
- RST  input  1  synchronous active-high reset.
- CS  input  1  command valid; sampled only in IDLE.
- CMD  input  1  1=write, 0=read.
- PRIORITY  input  8  captured for debug only; no functional effect.
- BURST  input  8  beat count; 0 means a zero-beat transaction.
- SIZE  input  8  log2 of bytes per beat.
- ADDR  input  WIDTH  start byte address.
- wDATA  input  WIDTH  write data; sampled on beat completion.
- rDATA  output  WIDTH  read data; valid while STATUS=1 in a read beat.
- STATUS  output  1  beat accepted in the current cycle; registered.
- BUSY  output  1  high in every state except IDLE.

Behaviour:
- Reset values: rDATA=0, STATUS=0, BUSY=0, state=IDLE, beat counter=0, wait counter=0. Memory contents are not reset.
- Reset mid-transaction aborts the transaction at the next edge; a partially written burst keeps the beats already written.
- States are IDLE, WAIT, BEAT, TURN.
- IDLE:
  - When CS=1 at an edge, latch CMD, BURST, SIZE and ADDR.
  - BURST=0 goes to TURN.
  - Otherwise go to WAIT if WAIT_STATES>0, else to BEAT.
  - STATUS is low during the command cycle.
- WAIT:
  - STATUS=0.
  - Count WAIT_STATES cycles, then go to BEAT.
- BEAT:
  - Lasts one cycle with STATUS=1.
  - Read: rDATA=mem[word index] during this cycle, loaded at the entering edge.
  - Write: wDATA is written at the closing edge.
  - Closing edge decrements the beat counter and advances the address by 1<<SIZE bytes.
  - Remaining beats go to WAIT or BEAT; the last beat goes to TURN.
  - Back-to-back beats with WAIT_STATES=0 hold STATUS high continuously.
- TURN:
  - One cycle, STATUS=0, CS ignored, then IDLE.
  - The earliest next command is therefore sampled 1 cycle after TURN.
- Word index = (addr >> log2(WIDTH/8)) mod DEPTH; addresses wrap silently.
- Effective SIZE = min(SIZE, log2(WIDTH/8)).
- Sub-word writes update only the byte lanes selected by the address low bits; other lanes are preserved.
- Sub-word reads return the full word; the master selects lanes.
- The address counter is WIDTH bits and wraps modulo 2^WIDTH.
- The beat counter is 8 bits, so BURST=255 yields 255 beats.
- CS asserted while BUSY is ignored. No queueing.
- rDATA holds its last value outside read beats and is 0 after reset.
- Latencies (command edge to first STATUS=1 cycle):
  - WAIT_STATES=0: 1 cycle.
  - Otherwise: WAIT_STATES+1 cycles.
  - Total transaction = 1 + BURST*(WAIT_STATES+1) + 1 cycles, including the TURN cycle.

Decomposition:
- Package generic_lscan_pkg:
  - typedef enum lscan_resp_state_e {IDLE, WAIT, BEAT, TURN}.
  - localparams CMD_READ=0, CMD_WRITE=1.
  - function for the byte-lane mask from address and size.
- Sub-module generic_lscan_mem: single-port, byte-enable, synchronous-write, registered-read array of DEPTH x WIDTH.
- All control logic stays in the top module.

Test Plan:
- Single write then read, WAIT_STATES=0:
  - Stimulus: CS=1, CMD=1, ADDR=0x10, BURST=1, SIZE=2, wDATA=0xDEADBEEF; then a read of 0x10.
  - Response: each transaction shows one STATUS pulse, 1 cycle after its command; rDATA=0xDEADBEEF during the read STATUS cycle; TURN keeps STATUS=0 for 1 cycle.
- Burst of 4, WAIT_STATES=2:
  - Stimulus: write 0x1..0x4 at ADDR=0x20, then read 4 beats.
  - Response: STATUS pattern 0,0,1 repeated 4 times; reads return 1,2,3,4; total 14 cycles per transaction.
- Byte write, SIZE=0:
  - Stimulus: ADDR=0x21, wDATA=0x0000AB00 over existing word 0x11223344.
  - Response: a read of word 0x20 returns 0x1122AB44.
- BURST=0 and ignored CS:
  - Stimulus: a BURST=0 command, plus CS held high through an active burst.
  - Response: the BURST=0 command gives no STATUS pulse, BUSY for 1 cycle (TURN); the mid-burst CS produces no new transaction.
- Wrap and reset:
  - Stimulus: with DEPTH=256, write ADDR=0x3FC with BURST=2; separately, assert RST during the second beat of a 3-beat burst.
  - Response: the burst writes indices 255 then 0. After the reset: STATUS=0 and BUSY=0 on the next edge; beat 1 is retained and beat 2 is not written.

Source files
------------

// File: rtl/generic_lscan_pkg.sv
// generic_lscan_pkg
// Shared types and helpers for the lscan responder slice.
//   lscan_resp_state_e : responder FSM states
//   CMD_READ/CMD_WRITE : CMD encodings
//   lane_mask()        : byte-lane enables for a beat, given address low bits and size
package generic_lscan_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    BEAT,
    TURN
  } lscan_resp_state_e;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  // Byte lanes touched by a beat of 2**eff_size bytes at addr_lo, within a word of
  // 2**lg_bytes bytes. Misaligned addresses are aligned down to the beat size.
  // Result is for up to 8 lanes; narrower words take the low bits.
  function automatic logic [7:0] lane_mask(input logic [2:0] addr_lo,
                                           input logic [1:0] eff_size,
                                           input logic [1:0] lg_bytes);
    logic [2:0] word_off;
    logic [2:0] base;
    logic [7:0] ones;
    word_off = 3'((4'd1 << lg_bytes) - 4'd1);
    base     = addr_lo & word_off & ~(3'((4'd1 << eff_size) - 4'd1));
    ones     = 8'((9'd1 << (4'd1 << eff_size)) - 9'd1);
    return ones << base;
  endfunction

endpackage

// File: rtl/generic_lscan_mem.sv
// generic_lscan_mem
// Single-port DEPTH x WIDTH word array with per-byte write enables.
// Writes happen at the clock edge; reads are registered and the read register
// only updates when re is high, so it holds its last value otherwise.
//   clk   : clock
//   rst   : synchronous active-high reset, clears the read register only
//   we    : write enable (byte lanes selected by be)
//   re    : load read register from addr
//   addr  : word index
//   be    : byte-lane enables
//   wdata : write data, lane aligned
//   rdata : registered read data
module generic_lscan_mem #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH/8-1:0]       be,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);
  import generic_lscan_pkg::*;

  localparam int NB = WIDTH / 8;

  logic [WIDTH-1:0] mem [DEPTH];

  // Array contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < NB; b++) begin
        if (be[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/generic_lscan_responder.sv
// generic_lscan_responder
// Slave-side lscan responder backed by a word memory. Accepts a command in IDLE,
// then paces each burst beat with WAIT_STATES STATUS-low cycles followed by a
// one-cycle STATUS-high beat, and finishes with a one-cycle TURN.
//   CLK      : clock
//   RST      : synchronous active-high reset
//   CS       : command valid, sampled only in IDLE
//   CMD      : 1 = write, 0 = read
//   PRIORITY : captured for debug, no functional effect
//   BURST    : beat count (0 = zero-beat transaction)
//   SIZE     : log2 bytes per beat, clamped to the word size
//   ADDR     : start byte address
//   wDATA    : write data, sampled at the closing edge of a write beat
//   rDATA    : read data, valid while STATUS=1 in a read beat, held otherwise
//   STATUS   : registered beat-accepted flag
//   BUSY     : high in every state except IDLE
//
// state | meaning
// IDLE  | waiting for CS; latches the command
// WAIT  | STATUS low, counting wait states before a beat
// BEAT  | one beat, STATUS high; write data captured at its closing edge
// TURN  | one turnaround cycle, CS ignored
module generic_lscan_responder #(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CS,
  input  logic             CMD,
  input  logic [7:0]       PRIORITY,
  input  logic [7:0]       BURST,
  input  logic [7:0]       SIZE,
  input  logic [WIDTH-1:0] ADDR,
  input  logic [WIDTH-1:0] wDATA,
  output logic [WIDTH-1:0] rDATA,
  output logic             STATUS,
  output logic             BUSY
);
  import generic_lscan_pkg::*;

  localparam int NB = WIDTH / 8;
  localparam int LG = (WIDTH == 64) ? 3 : 2;
  localparam int AW = $clog2(DEPTH);

  lscan_resp_state_e state, state_n;

  logic [WIDTH-1:0] addr_q, addr_n;
  logic [7:0]       beat_cnt, beat_n;
  logic [3:0]       wait_cnt, wait_n;
  logic             cmd_q;
  logic [1:0]       size_q;
  logic             status_q, status_n;
  logic             load_cmd;
  logic [1:0]       size_in;
  logic [WIDTH-1:0] step;
  logic [WIDTH-1:0] rd_addr;
  logic             mem_we, mem_re;
  logic [AW-1:0]    mem_addr;
  logic [NB-1:0]    mem_be;

  // Held for hierarchical debug probes only.
  logic [7:0]       dbg_priority_unused;

  assign size_in = (SIZE > 8'(LG)) ? 2'(LG) : SIZE[1:0];
  assign step    = {{(WIDTH-1){1'b0}}, 1'b1} << size_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state               <= IDLE;
      addr_q              <= '0;
      beat_cnt            <= '0;
      wait_cnt            <= '0;
      cmd_q               <= CMD_READ;
      size_q              <= '0;
      status_q            <= 1'b0;
      dbg_priority_unused <= '0;
    end else begin
      state    <= state_n;
      addr_q   <= addr_n;
      beat_cnt <= beat_n;
      wait_cnt <= wait_n;
      status_q <= status_n;
      if (load_cmd) begin
        cmd_q               <= CMD;
        size_q              <= size_in;
        dbg_priority_unused <= PRIORITY;
      end
    end
  end

  always_comb begin
    state_n  = state;
    addr_n   = addr_q;
    beat_n   = beat_cnt;
    wait_n   = wait_cnt;
    status_n = 1'b0;
    load_cmd = 1'b0;
    mem_we   = 1'b0;
    mem_re   = 1'b0;
    rd_addr  = addr_q;
    case (state)
      IDLE: begin
        if (CS) begin
          load_cmd = 1'b1;
          addr_n   = ADDR;
          beat_n   = BURST;
          rd_addr  = ADDR;
          if (BURST == 8'd0) begin
            state_n = TURN;
          end else if (WAIT_STATES > 0) begin
            state_n = WAIT;
            wait_n  = 4'(WAIT_STATES - 1);
          end else begin
            state_n  = BEAT;
            status_n = 1'b1;
            mem_re   = (CMD == CMD_READ);
          end
        end
      end
      WAIT: begin
        if (wait_cnt == 4'd0) begin
          state_n  = BEAT;
          status_n = 1'b1;
          mem_re   = (cmd_q == CMD_READ);
        end else begin
          wait_n = wait_cnt - 4'd1;
        end
      end
      BEAT: begin
        mem_we = (cmd_q == CMD_WRITE);
        addr_n = addr_q + step;
        beat_n = beat_cnt - 8'd1;
        if (beat_cnt == 8'd1) begin
          state_n = TURN;
        end else if (WAIT_STATES > 0) begin
          state_n = WAIT;
          wait_n  = 4'(WAIT_STATES - 1);
        end else begin
          // Back-to-back beat: the next read word must be fetched at this edge.
          state_n  = BEAT;
          status_n = 1'b1;
          mem_re   = (cmd_q == CMD_READ);
          rd_addr  = addr_q + step;
        end
      end
      TURN: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // A reset edge must not commit the write of the beat it interrupts.
  assign mem_addr = (state == BEAT && cmd_q == CMD_WRITE) ? addr_q[LG +: AW] : rd_addr[LG +: AW];
  assign mem_be   = NB'(lane_mask(addr_q[2:0], size_q, 2'(LG)));

  generic_lscan_mem #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_mem (
    .clk  (CLK),
    .rst  (RST),
    .we   (mem_we && !RST),
    .re   (mem_re && !RST),
    .addr (mem_addr),
    .be   (mem_be),
    .wdata(wDATA),
    .rdata(rDATA)
  );

  assign STATUS = status_q;
  assign BUSY   = (state != IDLE);

endmodule

// File: tb/tb_generic_lscan_responder.sv
module tb_generic_lscan_responder;

  localparam int W = 32;
  localparam int D = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst   [2];
  logic        cs    [2];
  logic        cmd   [2];
  logic [7:0]  prio  [2];
  logic [7:0]  burst [2];
  logic [7:0]  size  [2];
  logic [31:0] addr  [2];
  logic [31:0] wd    [2];
  logic [31:0] rd    [2];
  logic        st    [2];
  logic        busy  [2];

  // Reference word memory per responder instance.
  logic [31:0] mm [2][D];

  int checks   = 0;
  int failures = 0;

  generic_lscan_responder #(.WIDTH(W), .DEPTH(D), .WAIT_STATES(0)) dut0 (
    .CLK(clk), .RST(rst[0]), .CS(cs[0]), .CMD(cmd[0]), .PRIORITY(prio[0]),
    .BURST(burst[0]), .SIZE(size[0]), .ADDR(addr[0]), .wDATA(wd[0]),
    .rDATA(rd[0]), .STATUS(st[0]), .BUSY(busy[0]));

  generic_lscan_responder #(.WIDTH(W), .DEPTH(D), .WAIT_STATES(2)) dut1 (
    .CLK(clk), .RST(rst[1]), .CS(cs[1]), .CMD(cmd[1]), .PRIORITY(prio[1]),
    .BURST(burst[1]), .SIZE(size[1]), .ADDR(addr[1]), .wDATA(wd[1]),
    .rDATA(rd[1]), .STATUS(st[1]), .BUSY(busy[1]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'((a / 32'd4) % 32'(D));
  endfunction

  task automatic model_write(input int d, input logic [31:0] a, input int eff, input logic [31:0] data);
    int nb;
    int base;
    int ix;
    nb   = 1 << eff;
    base = (int'(a % 32'd4) / nb) * nb;
    ix   = widx(a);
    for (int l = base; l < base + nb; l++) mm[d][ix][l*8 +: 8] = data[l*8 +: 8];
  endtask

  // One full transaction; expected STATUS/BUSY per cycle comes from the beat
  // schedule (WAIT_STATES lows then a high, per beat, then one TURN cycle).
  task automatic run_txn(input int d, input bit c, input logic [31:0] a, input int bl,
                         input int sz, input logic [31:0] wbase, input bit use_const,
                         input logic [31:0] ebase, input bit hold_cs, input string tag);
    int ws;
    int eff;
    int len;
    int beat;
    logic [31:0] ca;
    logic es;
    ws   = (d == 0) ? 0 : 2;
    eff  = (sz > 2) ? 2 : sz;
    len  = bl * (ws + 1) + 1;
    beat = 0;
    ca   = a;
    @(negedge clk);
    chk1({tag, "/cmd_status"}, st[d], 1'b0);
    cs[d]    = 1'b1;
    cmd[d]   = c;
    addr[d]  = a;
    burst[d] = 8'(bl);
    size[d]  = 8'(sz);
    prio[d]  = 8'($urandom);
    wd[d]    = wbase;
    @(negedge clk);
    if (hold_cs) begin
      addr[d]  = 32'h0;
      burst[d] = 8'd7;
    end else begin
      cs[d] = 1'b0;
    end
    for (int k = 1; k <= len; k++) begin
      if (k > 1) @(negedge clk);
      es = (k < len) && ((k % (ws + 1)) == 0);
      chk1({tag, "/status"}, st[d], es);
      chk1({tag, "/busy"}, busy[d], 1'b1);
      if (k == len && hold_cs) cs[d] = 1'b0;
      if (es) begin
        if (c) begin
          wd[d] = wbase + 32'(beat);
          model_write(d, ca, eff, wbase + 32'(beat));
        end else begin
          chk({tag, "/rdata_model"}, rd[d], mm[d][widx(ca)]);
          if (use_const) chk({tag, "/rdata_const"}, rd[d], ebase + 32'(beat));
        end
        ca   = ca + (32'd1 << eff);
        beat = beat + 1;
      end
    end
    @(negedge clk);
    chk1({tag, "/idle_busy"}, busy[d], 1'b0);
    chk1({tag, "/idle_status"}, st[d], 1'b0);
  endtask

  typedef struct {
    int          d;
    bit          c;
    logic [31:0] a;
    int          bl;
    int          sz;
    logic [31:0] wb;
    bit          uc;
    logic [31:0] eb;
    bit          hold;
  } vec_t;

  vec_t vt[$];

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; cs[d] = 1'b0; cmd[d] = 1'b0; prio[d] = 8'h0;
      burst[d] = 8'h0; size[d] = 8'h0; addr[d] = 32'h0; wd[d] = 32'h0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk1("reset/status", st[d], 1'b0);
      chk1("reset/busy", busy[d], 1'b0);
      chk("reset/rdata", rd[d], 32'h0);
      rst[d] = 1'b0;
    end

    // Fill both memories so every later read has a known reference value.
    for (int d = 0; d < 2; d++) begin
      run_txn(d, 1'b1, 32'h0, 255, 2, $urandom, 1'b0, 32'h0, 1'b0, "fill");
      run_txn(d, 1'b1, 32'h3FC, 1, 2, $urandom, 1'b0, 32'h0, 1'b0, "fill_top");
    end

    vt.push_back('{0, 1'b1, 32'h10,  1, 2, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0});
    vt.push_back('{0, 1'b0, 32'h10,  1, 2, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0});
    vt.push_back('{1, 1'b1, 32'h20,  4, 2, 32'h1,        1'b0, 32'h0,        1'b0});
    vt.push_back('{1, 1'b0, 32'h20,  4, 2, 32'h0,        1'b1, 32'h1,        1'b0});
    vt.push_back('{1, 1'b1, 32'h20,  1, 2, 32'h11223344, 1'b0, 32'h0,        1'b0});
    vt.push_back('{1, 1'b1, 32'h21,  1, 0, 32'h0000AB00, 1'b0, 32'h0,        1'b0});
    vt.push_back('{1, 1'b0, 32'h20,  1, 2, 32'h0,        1'b1, 32'h1122AB44, 1'b0});
    vt.push_back('{0, 1'b1, 32'h30,  0, 2, 32'h0,        1'b0, 32'h0,        1'b0});
    vt.push_back('{0, 1'b1, 32'h50,  3, 2, 32'h5000,     1'b0, 32'h0,        1'b1});
    vt.push_back('{0, 1'b0, 32'h50,  3, 2, 32'h0,        1'b1, 32'h5000,     1'b0});
    vt.push_back('{0, 1'b1, 32'h3FC, 2, 2, 32'hA5A50000, 1'b0, 32'h0,        1'b0});
    vt.push_back('{0, 1'b0, 32'h3FC, 1, 2, 32'h0,        1'b1, 32'hA5A50000, 1'b0});
    vt.push_back('{0, 1'b0, 32'h0,   1, 2, 32'h0,        1'b1, 32'hA5A50001, 1'b0});
    vt.push_back('{1, 1'b1, 32'h60,  2, 7, 32'hC0DE0000, 1'b0, 32'h0,        1'b0});
    vt.push_back('{1, 1'b0, 32'h60,  2, 2, 32'h0,        1'b1, 32'hC0DE0000, 1'b0});

    foreach (vt[i]) begin
      run_txn(vt[i].d, vt[i].c, vt[i].a, vt[i].bl, vt[i].sz, vt[i].wb,
              vt[i].uc, vt[i].eb, vt[i].hold, $sformatf("vec%0d", i));
    end

    // Reset during the second beat of a 3-beat write on the zero-wait instance.
    @(negedge clk);
    cs[0] = 1'b1; cmd[0] = 1'b1; addr[0] = 32'h40; burst[0] = 8'd3; size[0] = 8'd2;
    wd[0] = 32'h77770000;
    @(negedge clk);
    cs[0] = 1'b0;
    chk1("midrst/beat1_status", st[0], 1'b1);
    wd[0] = 32'h77770000;
    model_write(0, 32'h40, 2, 32'h77770000);
    @(negedge clk);
    chk1("midrst/beat2_status", st[0], 1'b1);
    wd[0]  = 32'h77770001;
    rst[0] = 1'b1;
    @(negedge clk);
    chk1("midrst/status", st[0], 1'b0);
    chk1("midrst/busy", busy[0], 1'b0);
    chk("midrst/rdata", rd[0], 32'h0);
    rst[0] = 1'b0;
    run_txn(0, 1'b0, 32'h40, 1, 2, 32'h0, 1'b1, 32'h77770000, 1'b0, "midrst_beat1");
    run_txn(0, 1'b0, 32'h44, 1, 2, 32'h0, 1'b0, 32'h0, 1'b0, "midrst_beat2");

    // Randomized traffic against the reference memory.
    for (int n = 0; n < 60; n++) begin
      int d;
      d = int'($urandom_range(0, 1));
      run_txn(d, 1'($urandom_range(0, 1)), $urandom, int'($urandom_range(0, 5)),
              int'($urandom_range(0, 3)), $urandom, 1'b0, 32'h0, 1'($urandom_range(0, 1)),
              $sformatf("rand%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
